// File: rtl/data_mem_mc.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_mc
//  Purpose  : Multi-cycle data memory with a fixed request-to-response
//             latency. Supports word/half/byte loads and stores with sign or
//             zero extension, reports misaligned or reserved-size requests
//             as errors, and clears its whole contents on reset.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DEPTH_LOG2   log2 of the number of 32-bit words
//    LATENCY      cycles from acceptance to response (1..15)
//  Ports
//    clk          clock, rising edge
//    reset        synchronous active-high reset
//    req_valid    request present
//    req_ready    block can accept a request (IDLE only)
//    req_we       1 = store, 0 = load
//    req_size     00 word, 01 byte, 10 halfword, 11 reserved
//    req_unsigned zero-extend (1) / sign-extend (0) sub-word loads
//    req_addr     byte address
//    req_wdata    right-aligned store data
//    req_pc       PC of the issuing instruction (trace only)
//    rsp_valid    one-cycle response pulse
//    rsp_rdata    load result, 0 for stores and errors
//    rsp_err      misaligned / reserved-size request
//  Configuration
//    DM_TRACE_EN  when defined, each committed store prints a trace line
// ============================================================================
module data_mem_mc #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int C_DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;

  // Latched request fields
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_pc;

  logic [31:0] r_mem [C_DEPTH];
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_accept;
  logic        w_commit;

  // With LATENCY=1 the commit edge is also the accepting edge, so the live
  // request fields must be used instead of the (not yet latched) copies.
  logic        w_c_we;
  logic [1:0]  w_c_size;
  logic        w_c_unsigned;
  logic [31:0] w_c_addr;
  logic [31:0] w_c_wdata;
  logic [31:0] w_c_pc;

  logic [DEPTH_LOG2-1:0] w_idx;
  logic        w_mis;
  logic [31:0] w_rword;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_wword;
  logic        w_unused_bits;

  assign req_ready = (r_state == IDLE);
  assign rsp_valid = (r_state == RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

  assign w_accept = (r_state == IDLE) && req_valid;
  assign w_commit = (w_accept && (LATENCY == 1)) ||
                    ((r_state == WAIT) && (r_cnt <= 4'd1));

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY == 1) begin
            w_state_nxt = RESP;
            w_cnt_nxt   = 4'd0;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        // <= 1 rather than == 1 so a corrupted zero count cannot stall here
        if (r_cnt <= 4'd1) begin
          w_state_nxt = RESP;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt   = r_cnt - 4'd1;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // ------------------------------------------------------- request latch
  always_ff @(posedge clk) begin
    if (reset) begin
      r_we       <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_pc       <= 32'd0;
    end else if (w_accept) begin
      r_we       <= req_we;
      r_size     <= req_size;
      r_unsigned <= req_unsigned;
      r_addr     <= req_addr;
      r_wdata    <= req_wdata;
      r_pc       <= req_pc;
    end
  end

  assign w_c_we       = (r_state == IDLE) ? req_we       : r_we;
  assign w_c_size     = (r_state == IDLE) ? req_size     : r_size;
  assign w_c_unsigned = (r_state == IDLE) ? req_unsigned : r_unsigned;
  assign w_c_addr     = (r_state == IDLE) ? req_addr     : r_addr;
  assign w_c_wdata    = (r_state == IDLE) ? req_wdata    : r_wdata;
  assign w_c_pc       = (r_state == IDLE) ? req_pc       : r_pc;

  // Upper address bits are dropped (wrap modulo memory size); the PC only
  // feeds the optional trace.
  assign w_unused_bits = ^{w_c_pc, w_c_addr[31:DEPTH_LOG2+2]};

  // ------------------------------------------------------ datapath
  assign w_idx = w_c_addr[DEPTH_LOG2+1:2];

  assign w_mis = (w_c_size == 2'b11) ||
                 ((w_c_size == 2'b10) && w_c_addr[0]) ||
                 ((w_c_size == 2'b00) && (w_c_addr[1:0] != 2'b00));

  assign w_rword = r_mem[w_idx];
  assign w_byte  = w_rword[{w_c_addr[1:0], 3'b000} +: 8];
  assign w_half  = w_rword[{w_c_addr[1], 4'b0000} +: 16];

  always_comb begin
    w_load = w_rword;
    case (w_c_size)
      2'b01:   w_load = {{24{~w_c_unsigned & w_byte[7]}}, w_byte};
      2'b10:   w_load = {{16{~w_c_unsigned & w_half[15]}}, w_half};
      default: w_load = w_rword;
    endcase
  end

  // Read-modify-write merge: only the addressed lane(s) change.
  always_comb begin
    w_wword = w_rword;
    case (w_c_size)
      2'b00:   w_wword = w_c_wdata;
      2'b01:   w_wword[{w_c_addr[1:0], 3'b000} +: 8] = w_c_wdata[7:0];
      2'b10:   w_wword[{w_c_addr[1], 4'b0000} +: 16] = w_c_wdata[15:0];
      default: w_wword = w_rword;
    endcase
  end

  // Store commit and load sample share the edge entering RESP; the read
  // sees the pre-store word because the array update is non-blocking.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < C_DEPTH; i++) begin
        r_mem[i] <= 32'd0;
      end
    end else if (w_commit && w_c_we && !w_mis) begin
      r_mem[w_idx] <= w_wword;
    end
  end

  // Response registers are cleared every cycle that is not a commit, so
  // they read zero whenever rsp_valid is low.
  always_ff @(posedge clk) begin
    if (reset || !w_commit) begin
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_err   <= w_mis;
      r_rdata <= (w_mis || w_c_we) ? 32'd0 : w_load;
    end
  end

`ifdef DM_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset && w_commit && w_c_we && !w_mis) begin
      case (w_c_size)
        2'b01:   $display("@%h: *%h <= %h", w_c_pc, w_c_addr, w_c_wdata[7:0]);
        2'b10:   $display("@%h: *%h <= %h", w_c_pc, w_c_addr, w_c_wdata[15:0]);
        default: $display("@%h: *%h <= %h", w_c_pc, w_c_addr, w_c_wdata);
      endcase
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_mem_mc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_mc
//  Purpose  : Directed self-checking bench for data_mem_mc. A LATENCY=2
//             instance covers load/store formats, errors, wrap-around and
//             reset abort; a LATENCY=1 instance covers back-to-back issue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_data_mem_mc;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk;
  logic reset;

  // LATENCY=2 instance
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, req_pc;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  // LATENCY=1 instance
  logic        v1, ready1, we1, uns1;
  logic [1:0]  size1;
  logic [31:0] addr1, wdata1, pc1;
  logic        rv1, err1;
  logic [31:0] rd1;

  int   checks;
  int   errors;
  exp_t sbq[$];
  exp_t sbq1[$];

  data_mem_mc #(.DEPTH_LOG2(10), .LATENCY(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_pc(req_pc),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  data_mem_mc #(.DEPTH_LOG2(4), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(v1), .req_ready(ready1), .req_we(we1),
    .req_size(size1), .req_unsigned(uns1), .req_addr(addr1),
    .req_wdata(wdata1), .req_pc(pc1),
    .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request on the LATENCY=2 instance: push the expectation at issue,
  // pop and compare when the response pulse appears.
  task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err);
    exp_t e;
    exp_t got_e;
    logic rdy;
    logic acc;
    logic got;
    int   lat;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_pc = 32'h0000_4000 + addr;
    acc = 1'b0;
    for (int i = 0; i < 20; i++) begin
      rdy = req_ready;
      @(posedge clk);
      if (rdy) begin
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!acc) begin
      check({tag, "_accept"}, 32'(acc), 32'd1);
      req_valid = 1'b0;
      return;
    end
    sbq.push_back(e);
    lat = 1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      lat++;
    end
    check({tag, "_rspseen"}, 32'(got), 32'd1);
    if (got) begin
      check({tag, "_latency"}, 32'(lat), 32'd2);
      got_e = sbq.pop_front();
      check({tag, "_rdata"}, rsp_rdata, got_e.rdata);
      check({tag, "_err"}, 32'(rsp_err), 32'(got_e.err));
    end
  endtask

  initial begin
    exp_t e;
    logic rdy;
    int   k;
    int   nacc;
    int   nrsp;
    logic [31:0] last_store;

    checks = 0;
    errors = 0;
    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; req_pc = 32'd0;
    v1 = 1'b0; we1 = 1'b0; size1 = 2'b00; uns1 = 1'b0;
    addr1 = 32'd0; wdata1 = 32'd0; pc1 = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_rspvalid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);

    // Word store then load
    do_req("sw10", 1'b1, 2'b00, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    do_req("lw10", 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    // Byte store and byte loads
    do_req("sb13", 1'b1, 2'b01, 1'b0, 32'h13, 32'h000000AB, 32'h0, 1'b0);
    do_req("lw10b", 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 32'hABADBEEF, 1'b0);
    do_req("lb13", 1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 32'hFFFFFFAB, 1'b0);
    do_req("lbu13", 1'b0, 2'b01, 1'b1, 32'h13, 32'h0, 32'h000000AB, 1'b0);

    // Half store and half loads
    do_req("sh12", 1'b1, 2'b10, 1'b0, 32'h12, 32'hFFFF1234, 32'h0, 1'b0);
    do_req("lh12", 1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 32'h00001234, 1'b0);
    do_req("lh10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0);
    do_req("lhu10", 1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 32'h0000BEEF, 1'b0);

    // Misaligned / reserved requests
    do_req("sh11", 1'b1, 2'b10, 1'b0, 32'h11, 32'h00005678, 32'h0, 1'b1);
    do_req("lw12", 1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1);
    do_req("ressz", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1);
    do_req("lw10c", 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 32'h1234BEEF, 1'b0);

    // Address wrap-around
    do_req("sw1000", 1'b1, 2'b00, 1'b0, 32'h1000, 32'h00000055, 32'h0, 1'b0);
    do_req("lw0", 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h00000055, 1'b0);

    // Reset during WAIT of a store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h20;
    req_wdata = 32'h77777777;
    check("abort_ready_pre", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("abort_in_wait", 32'(req_ready), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("abort_rspvalid", 32'(rsp_valid), 32'd0);
    check("abort_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("abort_rspvalid2", 32'(rsp_valid), 32'd0);
    do_req("lw20", 1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0);
    do_req("lw10clr", 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0);

    // LATENCY=1: continuous req_valid, alternating store/load to word 4
    @(negedge clk);
    v1 = 1'b1; we1 = 1'b1; size1 = 2'b00; addr1 = 32'h4; wdata1 = 32'h100;
    k = 0; nacc = 0; nrsp = 0; last_store = 32'h0;
    for (int c = 0; c < 10; c++) begin
      check($sformatf("l1_ready_%0d", c), 32'(ready1), 32'((c % 2) == 0));
      check($sformatf("l1_rsp_%0d", c), 32'(rv1), 32'((c % 2) == 1));
      if (rv1) begin
        nrsp++;
        if (sbq1.size() == 0) begin
          check($sformatf("l1_sbq_%0d", c), 32'(sbq1.size()), 32'd1);
        end else begin
          e = sbq1.pop_front();
          check($sformatf("l1_rdata_%0d", c), rd1, e.rdata);
          check($sformatf("l1_err_%0d", c), 32'(err1), 32'(e.err));
        end
      end
      rdy = ready1;
      @(posedge clk);
      if (rdy) begin
        e.err = 1'b0;
        if (we1) begin
          e.rdata    = 32'h0;
          last_store = wdata1;
        end else begin
          e.rdata = last_store;
        end
        sbq1.push_back(e);
        nacc++;
      end
      @(negedge clk);
      if (rdy) begin
        k++;
        we1    = ((k % 2) == 0);
        wdata1 = 32'h100 + 32'(k);
      end
    end
    v1 = 1'b0;
    check("l1_accepts", 32'(nacc), 32'd5);
    check("l1_responses", 32'(nrsp), 32'd5);
    check("l1_sbq_empty", 32'(sbq1.size()), 32'd0);
    check("l2_sbq_empty", 32'(sbq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
